// File: rtl/sum_batch_accumulator.sv
// Sums BATCH consecutive 4-bit samples into an 8-bit total and holds the
// result on a valid/ready output until the downstream consumer takes it.
`timescale 1ns/1ps

module sum_batch_accumulator #(
  parameter int unsigned BATCH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sum_in,
  input  logic       sum_valid,
  output logic       sum_ready,
  input  logic       clear,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] batch_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   out_data_nxt;
  logic                out_valid_nxt;
  logic [DATA_W-1:0]   batch_count_nxt;

  // Handshake flags depend on state only, so they are valid during reset too.
  assign sum_ready = (state != HOLD);
  assign busy      = (state != IDLE);

  // Next-state and datapath updates; clear overrides every other event.
  always_comb begin
    state_nxt       = state;
    acc_nxt         = acc;
    cnt_nxt         = cnt;
    out_data_nxt    = out_data;
    out_valid_nxt   = out_valid;
    batch_count_nxt = batch_count;

    if (clear) begin
      state_nxt     = IDLE;
      acc_nxt       = '0;
      cnt_nxt       = '0;
      out_valid_nxt = 1'b0;
    end else if (state == HOLD) begin
      if (out_valid && out_ready) begin
        out_valid_nxt   = 1'b0;
        batch_count_nxt = batch_count + DATA_W'(1);
        state_nxt       = IDLE;
      end
    end else if (sum_valid && sum_ready) begin
      if (cnt == LAST_CNT) begin
        out_data_nxt  = acc + DATA_W'(sum_in);
        out_valid_nxt = 1'b1;
        acc_nxt       = '0;
        cnt_nxt       = '0;
        state_nxt     = HOLD;
      end else begin
        acc_nxt   = acc + DATA_W'(sum_in);
        cnt_nxt   = cnt + CNT_W'(1);
        state_nxt = ACCUM;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      batch_count <= '0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      out_data    <= out_data_nxt;
      out_valid   <= out_valid_nxt;
      batch_count <= batch_count_nxt;
    end
  end

endmodule

// File: tb/tb_sum_batch_accumulator.sv
// Bench for sum_batch_accumulator: directed scenarios on BATCH=4/16/1
// instances plus a randomized run against a transaction-level model.
`timescale 1ns/1ps

module tb_sum_batch_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       sum_valid;
  logic       out_ready;
  logic [3:0] sum_in;

  // Index 0: BATCH=4, index 1: BATCH=16, index 2: BATCH=1
  logic [7:0] od [3];
  logic       ov [3];
  logic       sr [3];
  logic       bz [3];
  logic [7:0] bc [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: running total and sample count of the open batch,
  // pending result (-1 = none), last completed total, handshake count.
  int m_acc  [3];
  int m_n    [3];
  int m_pend [3];
  int m_last [3];
  int m_hs   [3];

  always #5 clk = ~clk;

  sum_batch_accumulator #(.BATCH(4)) u_b4 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sr[0]), .clear(clear), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .busy(bz[0]), .batch_count(bc[0]));

  sum_batch_accumulator #(.BATCH(16)) u_b16 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sr[1]), .clear(clear), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .busy(bz[1]), .batch_count(bc[1]));

  sum_batch_accumulator #(.BATCH(1)) u_b1 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sr[2]), .clear(clear), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .busy(bz[2]), .batch_count(bc[2]));

  function automatic int batch_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; clear = 1'b0; sum_valid = 1'b0; out_ready = 1'b0; sum_in = 4'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; sum_valid = 1'b0; out_ready = 1'b0; sum_in = 4'd0;
    #2;
    n_checks++; if (od[0] !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", od[0]); end
    n_checks++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov[0]); end
    n_checks++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bz[0]); end
    n_checks++; if (bc[0] !== 8'h00) begin n_fail++; $display("FAIL reset_batch_count got %h want 00", bc[0]); end
    n_checks++; if (sr[0] !== 1'b1) begin n_fail++; $display("FAIL reset_sum_ready got %b want 1", sr[0]); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++; if (sr[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_sum_ready got %b want 1", sr[0]); end
    n_checks++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", bz[0]); end
  endtask

  task automatic test_basic();
    apply_reset();
    out_ready = 1'b1;
    sum_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sum_in = 4'(k);
      tick();
    end
    n_checks++; if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b want 1", ov[0]); end
    n_checks++; if (od[0] !== 8'h0A) begin n_fail++; $display("FAIL basic_out_data got %h want 0a", od[0]); end
    n_checks++; if (sr[0] !== 1'b0) begin n_fail++; $display("FAIL basic_sum_ready_hold got %b want 0", sr[0]); end
    n_checks++; if (bc[0] !== 8'h00) begin n_fail++; $display("FAIL basic_count_before got %h want 00", bc[0]); end
    sum_valid = 1'b0;
    tick();
    n_checks++; if (bc[0] !== 8'h01) begin n_fail++; $display("FAIL basic_count_after got %h want 01", bc[0]); end
    n_checks++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b want 0", ov[0]); end
    n_checks++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle got %b want 0", bz[0]); end
  endtask

  task automatic test_max_sums();
    apply_reset();
    out_ready = 1'b0;
    sum_valid = 1'b1;
    sum_in    = 4'd15;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 3) begin
        n_checks++; if (ov[0] !== 1'b1 || od[0] !== 8'h3C) begin n_fail++; $display("FAIL max_b4 got valid=%b data=%h want 1/3c", ov[0], od[0]); end
      end
      if (k == 14) begin
        n_checks++; if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL max_b16_early got valid=%b want 0", ov[1]); end
      end
      if (k == 15) begin
        n_checks++; if (ov[1] !== 1'b1 || od[1] !== 8'hF0) begin n_fail++; $display("FAIL max_b16 got valid=%b data=%h want 1/f0", ov[1], od[1]); end
      end
    end
    apply_reset();
    sum_valid = 1'b1;
    sum_in    = 4'd7;
    tick();
    n_checks++; if (ov[2] !== 1'b1 || od[2] !== 8'h07) begin n_fail++; $display("FAIL b1_single got valid=%b data=%h want 1/07", ov[2], od[2]); end
    n_checks++; if (sr[2] !== 1'b0) begin n_fail++; $display("FAIL b1_ready got %b want 0", sr[2]); end
    sum_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (bc[2] !== 8'h01 || ov[2] !== 1'b0) begin n_fail++; $display("FAIL b1_handshake got count=%h valid=%b want 01/0", bc[2], ov[2]); end
  endtask

  task automatic test_hold_backpressure();
    apply_reset();
    out_ready = 1'b0;
    sum_valid = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      sum_in = 4'(k);
      tick();
    end
    n_checks++; if (ov[0] !== 1'b1 || od[0] !== 8'h1A) begin n_fail++; $display("FAIL hold_enter got valid=%b data=%h want 1/1a", ov[0], od[0]); end
    for (int k = 0; k < 5; k++) begin
      sum_in = 4'($urandom_range(15));
      tick();
      n_checks++;
      if (ov[0] !== 1'b1 || od[0] !== 8'h1A || sr[0] !== 1'b0 || bc[0] !== 8'h00) begin
        n_fail++;
        $display("FAIL hold_stable cyc %0d got valid=%b data=%h ready=%b count=%h want 1/1a/0/00", k, ov[0], od[0], sr[0], bc[0]);
      end
    end
    out_ready = 1'b1;
    sum_valid = 1'b0;
    tick();
    n_checks++; if (bc[0] !== 8'h01 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL hold_release got count=%h valid=%b want 01/0", bc[0], ov[0]); end
    out_ready = 1'b0;
    tick();
    n_checks++; if (bc[0] !== 8'h01) begin n_fail++; $display("FAIL hold_single_count got %h want 01", bc[0]); end
  endtask

  task automatic test_clear();
    apply_reset();
    out_ready = 1'b1;
    sum_valid = 1'b1;
    sum_in    = 4'd9;
    repeat (4) tick();
    sum_valid = 1'b0;
    tick();
    sum_valid = 1'b1;
    sum_in    = 4'd2;
    tick();
    sum_in = 4'd3;
    tick();
    clear  = 1'b1;
    sum_in = 4'd9;
    tick();
    clear = 1'b0;
    n_checks++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b want 0", bz[0]); end
    n_checks++; if (ov[0] !== 1'b0 || od[0] !== 8'h24) begin n_fail++; $display("FAIL clear_out got valid=%b data=%h want 0/24", ov[0], od[0]); end
    n_checks++; if (bc[0] !== 8'h01) begin n_fail++; $display("FAIL clear_count got %h want 01", bc[0]); end
    sum_in = 4'd1;
    repeat (4) tick();
    n_checks++; if (ov[0] !== 1'b1 || od[0] !== 8'h04) begin n_fail++; $display("FAIL clear_next_batch got valid=%b data=%h want 1/04", ov[0], od[0]); end
    sum_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    sum_valid = 1'b1;
    sum_in    = 4'd3;
    repeat (4) tick();
    sum_valid = 1'b0;
    n_checks++; if (ov[0] !== 1'b1 || od[0] !== 8'h0C) begin n_fail++; $display("FAIL areset_pre got valid=%b data=%h want 1/0c", ov[0], od[0]); end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", ov[0]); end
    n_checks++; if (od[0] !== 8'h00) begin n_fail++; $display("FAIL areset_data got %h want 00", od[0]); end
    n_checks++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", bz[0]); end
    n_checks++; if (sr[0] !== 1'b1) begin n_fail++; $display("FAIL areset_ready got %b want 1", sr[0]); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    apply_reset();
    out_ready = 1'b1;
    sum_valid = 1'b1;
    for (int b = 0; b < 256; b++) begin
      int tot;
      tot = 0;
      for (int k = 0; k < 4; k++) begin
        int s;
        s      = int'($urandom_range(15));
        sum_in = 4'(s);
        tot   += s;
        tick();
      end
      n_checks++;
      if (ov[0] !== 1'b1 || od[0] !== 8'(tot)) begin
        n_fail++;
        $display("FAIL b2b_total batch %0d got valid=%b data=%h want 1/%h", b, ov[0], od[0], 8'(tot));
      end
      tick();
      n_checks++;
      if (bc[0] !== 8'((b + 1) % 256)) begin
        n_fail++;
        $display("FAIL wrap_count batch %0d got %h want %h", b, bc[0], 8'((b + 1) % 256));
      end
    end
    sum_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_n[i] = 0; m_pend[i] = -1; m_last[i] = 0; m_hs[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      sum_valid = ($urandom_range(3) != 0);
      sum_in    = 4'($urandom_range(15));
      out_ready = ($urandom_range(1) == 1);
      clear     = ($urandom_range(24) == 0);
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (clear) begin
          m_acc[i] = 0; m_n[i] = 0; m_pend[i] = -1;
        end else if (m_pend[i] >= 0) begin
          if (out_ready) begin
            m_hs[i]++;
            m_pend[i] = -1;
          end
        end else if (sum_valid) begin
          m_acc[i] += int'(sum_in);
          m_n[i]++;
          if (m_n[i] == batch_of(i)) begin
            m_pend[i] = m_acc[i];
            m_last[i] = m_acc[i];
            m_acc[i]  = 0;
            m_n[i]    = 0;
          end
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        logic       e_ov, e_sr, e_bz;
        logic [7:0] e_od, e_bc;
        e_ov = (m_pend[i] >= 0);
        e_sr = (m_pend[i] < 0);
        e_bz = (m_n[i] > 0) || (m_pend[i] >= 0);
        e_od = 8'(m_last[i]);
        e_bc = 8'(m_hs[i] % 256);
        n_checks++;
        if (ov[i] !== e_ov || od[i] !== e_od || sr[i] !== e_sr || bz[i] !== e_bz || bc[i] !== e_bc) begin
          n_fail++;
          $display("FAIL random B=%0d cyc %0d got valid=%b data=%h ready=%b busy=%b count=%h want %b/%h/%b/%b/%h",
                   batch_of(i), c, ov[i], od[i], sr[i], bz[i], bc[i], e_ov, e_od, e_sr, e_bz, e_bc);
        end
      end
    end
    clear     = 1'b0;
    sum_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_sums();
    test_hold_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_batch_accumulator.md
SUM_BATCH_ACCUMULATOR -- requirements
Module: sum_batch_accumulator

Interface
REQ-001 SHALL have parameter BATCH, default 4, number of sums per batch; legal range 1..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sum_in  input  4  4-bit sum from the upstream nibble adder stage, unsigned.
REQ-005 SHALL have port sum_valid  input  1  sum_in valid this cycle.
REQ-006 SHALL have port sum_ready  output  1  block can accept a sum this cycle.
REQ-007 SHALL have port clear  input  1  synchronous abort and flush of the current batch.
REQ-008 SHALL have port out_data  output  8  batch total, unsigned.
REQ-009 SHALL have port out_valid  output  1  out_data holds a completed batch total.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE.
REQ-012 SHALL have port batch_count  output  8  completed-batch handshakes, modulo 256.

Function
REQ-013 SHALL implement states IDLE (cnt=0, no result pending), ACCUM (0<cnt<BATCH), HOLD (result pending).
REQ-014 SHALL drive sum_ready = 1 in IDLE and ACCUM and 0 in HOLD, combinationally from state only.
REQ-015 SHALL accept a sum at a rising edge when sum_valid and sum_ready are both 1; otherwise acc and cnt unchanged.
REQ-016 SHALL, on accept with cnt < BATCH-1, set acc <= acc + zero-extended sum_in (8-bit), cnt <= cnt+1, state ACCUM.
REQ-017 SHALL, on accept with cnt = BATCH-1, set out_data <= acc + sum_in, out_valid <= 1, acc <= 0, cnt <= 0, state HOLD.
REQ-018 SHALL assert out_valid in the cycle after the edge accepting the last sample (latency 1).
REQ-019 SHALL, for BATCH=1, complete a batch on every accepted sum (IDLE -> HOLD directly).
REQ-020 SHALL never overflow: max total 15*16 = 240 fits 8 bits; no saturation logic required.
REQ-021 SHALL hold out_data and out_valid stable in HOLD until out_ready is sampled 1.
REQ-022 SHALL, on out_valid and out_ready at an edge, clear out_valid, increment batch_count (255 wraps to 0), go to IDLE.
REQ-023 SHALL ignore sum_valid in HOLD (no accept, no data loss upstream, since sum_ready=0).
REQ-024 SHALL ignore out_ready when out_valid is 0.
REQ-025 SHALL give clear priority over all other events: at the edge, acc=0, cnt=0, out_valid=0, state IDLE; out_data and batch_count unchanged; a sum presented with clear is discarded.
REQ-026 SHALL allow back-to-back accepts every cycle in IDLE/ACCUM; peak throughput one batch per BATCH+1 cycles with out_ready held 1.

Reset
REQ-027 SHALL, while reset is 1, force state IDLE, acc=0, cnt=0, out_data=0x00, out_valid=0, batch_count=0x00, busy=0, independent of clk.
REQ-028 SHALL drive sum_ready = 1 during and immediately after reset.
REQ-029 SHALL, on reset asserted mid-batch or in HOLD, discard partial and pending results with no handshake.
REQ-030 SHALL resume normal operation at the first rising edge after reset deasserts.

Verification (BATCH=4 unless stated)
REQ-031 SHALL cover: sums 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid one cycle after 4th accept, out_data=0x0A, sum_ready=0 that cycle, batch_count=1 next edge.
REQ-032 SHALL cover: four sums of 15 -> out_data=0x3C; BATCH=16 sixteen sums of 15 -> out_data=0xF0; BATCH=1 sum 7 -> out_data=0x07 next cycle.
REQ-033 SHALL cover: batch complete with out_ready=0 for 5 cycles and sum_valid=1 throughout -> out_data/out_valid stable, no sums accepted, batch_count increments exactly once on handshake.
REQ-034 SHALL cover: sums 2,3 accepted, clear pulsed, then four sums of 1 -> out_data=0x04, busy=0 the cycle after clear.
REQ-035 SHALL cover: reset asserted asynchronously mid-cycle while in HOLD -> out_valid=0, out_data=0x00, busy=0, sum_ready=1 before next clk edge.
REQ-036 SHALL cover: 256 completed batch handshakes from reset -> batch_count returns to 0x00.
